reduce_sum_sequencer: RTL and testbench
=======================================

Name: reduce_sum_sequencer

Overview:
- Sequenced signed-int8 sum reduction over a vector streamed in Lanes-wide beats.
- Per beat: a combinational Lanes-input sum stage produces a partial sum; the partial sum is accumulated in a wide register over a runtime-configured number of beats.
- The total is emitted on a valid/ready output.
- Sits between an activation/weight streamer and downstream bias/requant logic in the inference datapath.

Parameters:
- Lanes, 4: int8 elements per input beat; power of two, ≥2.
- AccW, 16: accumulator and output width in bits; must be ≥ 8+log2(Lanes).
- MaxBeats, 16: largest supported beats-per-vector; count register is $clog2(MaxBeats+1) bits.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- cfg_beats_in  input  $clog2(MaxBeats+1)  beats per vector; sampled only on first-beat accept.
- in_valid_in  input  1  input beat valid.
- in_ready_out  output  1  input beat accepted when in_valid_in && in_ready_out.
- in_data_in  input  Lanes*8  Lanes packed signed int8; lane 0 = bits [7:0].
- out_valid_out  output  1  result valid.
- out_ready_in  input  1  downstream accepts result.
- out_data_out  output  AccW  signed vector sum.
- busy_out  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, acc=0, count=0, beats_lat=0. Outputs in_ready_out=0 for the reset cycle only, then 1 in IDLE; out_valid_out=0, out_data_out=0, busy_out=0.
- Lane sum: each lane is sign-extended to AccW, then all lanes are summed combinationally. The result is exact because AccW ≥ 8+log2(Lanes).
- FSM, IDLE:
  - in_ready_out=1.
  - On accept: beats_lat = max(cfg_beats_in,1), clamped to MaxBeats; acc=lane_sum; count=1.
  - Next state DONE if beats_lat==1, else ACCUM.
- FSM, ACCUM:
  - in_ready_out=1.
  - On accept: acc=acc+lane_sum (AccW two's-complement wrap); count++.
  - When the accepted beat makes count==beats_lat, next state is DONE.
  - No accept: hold all state.
- FSM, DONE:
  - in_ready_out=0; out_valid_out=1; out_data_out=acc, stable until accepted.
  - On out_ready_in: next state IDLE; out_data_out held at last value; out_valid_out drops next cycle.
- Latency: out_valid_out rises the cycle after the last beat is accepted. Throughput: beats_lat+1 cycles per vector with no backpressure. No overlap between DONE and the next vector's first beat.
- in_valid_in low mid-vector: pause indefinitely, partial sum retained.
- cfg_beats_in changes mid-vector: ignored; only beats_lat is used.
- cfg_beats_in=0: treated as 1. cfg_beats_in>MaxBeats: clamped to MaxBeats.
- out_ready_in high while not in DONE: ignored.
- Reset asserted mid-vector or in DONE: immediate return to reset values; partial result discarded, never emitted.
- out_valid_out is never deasserted without acceptance, except by reset.

Optional Feature:
- Macro REDUCE_SAT_EN.
- Defined: every accumulate (and the IDLE load) saturates to the signed AccW range [-2^(AccW-1), 2^(AccW-1)-1]. Once saturated, later opposite-sign beats pull the value back from the clamp.
- Undefined: plain two's-complement wrap at AccW bits.
- Ports and timing are identical in both builds.

Test Plan (Lanes=4, AccW=16, MaxBeats=16):
- Single beat: cfg=1, in_data={8'd4,8'd3,8'd2,8'd1} → out_data=10 exactly one cycle after accept; in_ready low while DONE.
- Signed multi-beat: cfg=3, beats all-lanes {-128}, {127}, {1,1,1,1} → out_data=-512+508+4=0.
- Gaps and backpressure: cfg=4, beats of all-ones with in_valid gaps of 2 cycles, out_ready held low 5 cycles → out_data=16; value stable, valid held, no extra beats accepted.
- Config edges: cfg=0 → completes after 1 beat. cfg=20 → completes after 16 beats. cfg changed to 2 during a cfg=5 vector → still 5 beats.
- Reset mid-vector: after 2 of 4 beats pulse rst_n_in low → all outputs zero immediately. Next vector cfg=1, data {0,0,0,5} → out_data=5, with no residue from the aborted vector.
- Overflow: cfg=16, all lanes 127 → 8128 (no wrap). Then AccW=12 build with cfg=16, all lanes 127 → wraps to -64 without REDUCE_SAT_EN, or clamps to 2047 with it.

Source files
------------

// File: rtl/reduce_sum_sequencer_if.sv
// Handshake bundle for reduce_sum_sequencer: configuration, input beat stream and result stream.
// master = upstream/downstream driver side, slave = the reduction block.
interface reduce_sum_sequencer_if #(
   parameter int Lanes    = 4,
   parameter int AccW     = 16,
   parameter int MaxBeats = 16
);
   localparam int CntW = $clog2(MaxBeats + 1);

   logic [CntW-1:0]        cfg_beats_in;
   logic                   in_valid_in;
   logic                   in_ready_out;
   logic [Lanes*8-1:0]     in_data_in;
   logic                   out_valid_out;
   logic                   out_ready_in;
   logic signed [AccW-1:0] out_data_out;
   logic                   busy_out;

   modport master (
      output cfg_beats_in, in_valid_in, in_data_in, out_ready_in,
      input  in_ready_out, out_valid_out, out_data_out, busy_out
   );

   modport slave (
      input  cfg_beats_in, in_valid_in, in_data_in, out_ready_in,
      output in_ready_out, out_valid_out, out_data_out, busy_out
   );
endinterface

// File: rtl/reduce_sum_sequencer.sv
// Signed int8 vector sum: per-beat lane adder feeding a wide accumulator over a configured beat count.
// Define REDUCE_SAT_EN to saturate the accumulator instead of wrapping.
module reduce_sum_sequencer #(
   parameter int Lanes    = 4,
   parameter int AccW     = 16,
   parameter int MaxBeats = 16
) (
   input logic                 clk_in,
   input logic                 rst_n_in,
   reduce_sum_sequencer_if.slave bus
);
   localparam int CntW = $clog2(MaxBeats + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e                 state_r, state_s;
   logic signed [AccW-1:0] lane_sum_s;
   logic signed [AccW-1:0] acc_r, acc_s;
   logic signed [AccW-1:0] out_data_r;
   logic [CntW-1:0]        count_r, count_s;
   logic [CntW-1:0]        beats_r, beats_s;
   logic [CntW-1:0]        cfg_clamp_s;
   logic                   in_ready_r;
   logic                   out_valid_r;
   logic                   busy_r;
   logic                   accept_s;

   // Accumulator add: wraps at AccW bits, or clamps to the signed range when saturation is enabled.
   function automatic logic signed [AccW-1:0] acc_add(input logic signed [AccW-1:0] a,
                                                      input logic signed [AccW-1:0] b);
`ifdef REDUCE_SAT_EN
      logic signed [AccW:0] wide;
      wide = {a[AccW-1], a} + {b[AccW-1], b};
      if (wide[AccW] != wide[AccW-1]) begin
         acc_add = wide[AccW] ? {1'b1, {(AccW-1){1'b0}}} : {1'b0, {(AccW-1){1'b1}}};
      end else begin
         acc_add = wide[AccW-1:0];
      end
`else
      acc_add = a + b;
`endif
   endfunction

   // Combinational lane adder; exact because AccW covers 8+log2(Lanes) bits.
   always_comb begin
      lane_sum_s = {AccW{1'b0}};
      for (int i = 0; i < Lanes; i++) begin
         lane_sum_s = lane_sum_s + {{(AccW-8){bus.in_data_in[i*8+7]}}, bus.in_data_in[i*8 +: 8]};
      end
   end

   // Beat count used for a new vector: zero means one beat, oversize clamps to MaxBeats.
   always_comb begin
      if (bus.cfg_beats_in == {CntW{1'b0}}) begin
         cfg_clamp_s = CntW'(1);
      end else if (bus.cfg_beats_in > CntW'(MaxBeats)) begin
         cfg_clamp_s = CntW'(MaxBeats);
      end else begin
         cfg_clamp_s = bus.cfg_beats_in;
      end
   end

   assign accept_s = bus.in_valid_in && in_ready_r;

   // Next-state and datapath update logic.
   always_comb begin
      state_s = state_r;
      acc_s   = acc_r;
      count_s = count_r;
      beats_s = beats_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               beats_s = cfg_clamp_s;
               acc_s   = acc_add({AccW{1'b0}}, lane_sum_s);
               count_s = CntW'(1);
               state_s = (cfg_clamp_s == CntW'(1)) ? DONE : ACCUM;
            end else begin
               state_s = IDLE;
            end
         end
         ACCUM: begin
            if (accept_s) begin
               acc_s   = acc_add(acc_r, lane_sum_s);
               count_s = count_r + CntW'(1);
               state_s = (count_r + CntW'(1) == beats_r) ? DONE : ACCUM;
            end else begin
               state_s = ACCUM;
            end
         end
         DONE: begin
            if (bus.out_ready_in) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_r     <= IDLE;
         acc_r       <= {AccW{1'b0}};
         count_r     <= {CntW{1'b0}};
         beats_r     <= {CntW{1'b0}};
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= {AccW{1'b0}};
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         acc_r       <= acc_s;
         count_r     <= count_s;
         beats_r     <= beats_s;
         in_ready_r  <= (state_s != DONE);
         out_valid_r <= (state_s == DONE);
         busy_r      <= (state_s != IDLE);
         // Result register only loads in DONE so it holds after the handshake.
         if (state_s == DONE) begin
            out_data_r <= acc_s;
         end
      end
   end

   assign bus.in_ready_out  = in_ready_r;
   assign bus.out_valid_out = out_valid_r;
   assign bus.out_data_out  = out_data_r;
   assign bus.busy_out      = busy_r;
endmodule

// File: tb/tb_reduce_sum_sequencer.sv
// Randomized and directed bench for reduce_sum_sequencer against a plain-arithmetic vector-sum model.
module tb_reduce_sum_sequencer;
   localparam int Lanes    = 4;
   localparam int AccW     = 16;
   localparam int MaxBeats = 16;

   typedef logic [31:0] beat_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   reduce_sum_sequencer_if #(.Lanes(Lanes), .AccW(AccW), .MaxBeats(MaxBeats)) bus ();
   reduce_sum_sequencer_if #(.Lanes(Lanes), .AccW(12), .MaxBeats(MaxBeats)) bus12 ();

   reduce_sum_sequencer #(.Lanes(Lanes), .AccW(AccW), .MaxBeats(MaxBeats)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .bus(bus));
   reduce_sum_sequencer #(.Lanes(Lanes), .AccW(12), .MaxBeats(MaxBeats)) dut12 (
      .clk_in(clk), .rst_n_in(rst_n), .bus(bus12));

   task automatic chk(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int eff_beats(input int cfg);
      if (cfg == 0) return 1;
      if (cfg > MaxBeats) return MaxBeats;
      return cfg;
   endfunction

   // Vector total from the lane values, wrapped or saturated at w bits.
   function automatic longint model_sum(input beat_t beats[$], input int w);
      longint acc, lo, hi, s;
      acc = 0;
      lo  = -(longint'(1) <<< (w - 1));
      hi  = (longint'(1) <<< (w - 1)) - 1;
      foreach (beats[b]) begin
         s = 0;
         for (int l = 0; l < Lanes; l++) begin
            byte v;
            v = beats[b][8*l +: 8];
            s += longint'(v);
         end
         acc += s;
`ifdef REDUCE_SAT_EN
         if (acc > hi) acc = hi;
         if (acc < lo) acc = lo;
`endif
      end
`ifndef REDUCE_SAT_EN
      acc = acc & ((longint'(1) <<< w) - 1);
      if (acc > hi) acc -= (longint'(1) <<< w);
`endif
      return acc;
   endfunction

   task automatic send_beat(input beat_t d);
      int n;
      n = 0;
      bus.in_data_in  = d;
      bus.in_valid_in = 1'b1;
      while (!bus.in_ready_out && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) chk("beat_timeout", 0, 1);
      @(posedge clk); #1;
      bus.in_valid_in = 1'b0;
   endtask

   task automatic run_vector(input string tag, input int cfg, input beat_t beats[$],
                             input int gap, input int hold, input int cfg_mid);
      longint exp;
      exp = model_sum(beats, AccW);
      bus.cfg_beats_in = 5'(cfg);
      foreach (beats[i]) begin
         if (i > 0) begin
            repeat (gap) begin
               @(posedge clk); #1;
            end
            chk({tag, "_busy"}, bus.busy_out, 1);
            chk({tag, "_early"}, bus.out_valid_out, 0);
         end
         send_beat(beats[i]);
         if (i == 0 && cfg_mid >= 0) bus.cfg_beats_in = 5'(cfg_mid);
      end
      chk({tag, "_valid"}, bus.out_valid_out, 1);
      chk({tag, "_ready_lo"}, bus.in_ready_out, 0);
      chk({tag, "_data"}, bus.out_data_out, exp);
      for (int h = 0; h < hold; h++) begin
         bus.in_valid_in = 1'b1;
         bus.in_data_in  = 32'h7f7f7f7f;
         @(posedge clk); #1;
         chk({tag, "_hold_valid"}, bus.out_valid_out, 1);
         chk({tag, "_hold_data"}, bus.out_data_out, exp);
         chk({tag, "_hold_ready"}, bus.in_ready_out, 0);
      end
      bus.in_valid_in  = 1'b0;
      bus.out_ready_in = 1'b1;
      @(posedge clk); #1;
      bus.out_ready_in = 1'b0;
      chk({tag, "_drop"}, bus.out_valid_out, 0);
      chk({tag, "_kept"}, bus.out_data_out, exp);
      chk({tag, "_idle"}, bus.busy_out, 0);
   endtask

   initial begin
      beat_t  q[$];
      int     cfg, n, cyc;
      longint exp12;

      bus.cfg_beats_in   = 5'd0;
      bus.in_valid_in    = 1'b0;
      bus.in_data_in     = 32'd0;
      bus.out_ready_in   = 1'b0;
      bus12.cfg_beats_in = 5'd16;
      bus12.in_valid_in  = 1'b0;
      bus12.in_data_in   = 32'd0;
      bus12.out_ready_in = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", bus.in_ready_out, 0);
      chk("rst_valid", bus.out_valid_out, 0);
      chk("rst_data", bus.out_data_out, 0);
      chk("rst_busy", bus.busy_out, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", bus.in_ready_out, 1);

      q = '{32'h04030201};
      run_vector("single", 1, q, 0, 0, -1);
      chk("single_const", bus.out_data_out, 10);

      q = '{32'h80808080, 32'h7f7f7f7f, 32'h01010101};
      run_vector("signed", 3, q, 0, 0, -1);

      q = '{32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101};
      run_vector("gaps", 4, q, 2, 5, -1);
      chk("gaps_const", bus.out_data_out, 16);

      q = '{32'hfbfcfdfe};
      run_vector("cfg0", 0, q, 0, 0, -1);

      q.delete();
      for (int i = 0; i < 16; i++) q.push_back($urandom);
      run_vector("cfg20", 20, q, 0, 1, -1);

      q.delete();
      for (int i = 0; i < 5; i++) q.push_back($urandom);
      run_vector("cfgchg", 5, q, 1, 0, 2);

      // Abort a vector halfway and confirm nothing of it survives.
      bus.cfg_beats_in = 5'd4;
      send_beat(32'h11223344);
      send_beat(32'h55667788);
      rst_n = 1'b0;
      #1;
      chk("abort_ready", bus.in_ready_out, 0);
      chk("abort_valid", bus.out_valid_out, 0);
      chk("abort_data", bus.out_data_out, 0);
      chk("abort_busy", bus.busy_out, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      q = '{32'h05000000};
      run_vector("after_abort", 1, q, 0, 0, -1);
      chk("after_abort_const", bus.out_data_out, 5);

      q.delete();
      for (int i = 0; i < 16; i++) q.push_back(32'h7f7f7f7f);
      run_vector("ovf16", 16, q, 0, 0, -1);
      chk("ovf16_const", bus.out_data_out, 8128);

      // Narrow accumulator instance: 16 beats of 508 exceed 12 bits.
      exp12 = model_sum(q, 12);
      bus12.in_data_in  = 32'h7f7f7f7f;
      bus12.in_valid_in = 1'b1;
      n = 0;
      cyc = 0;
      while (n < 16 && cyc < 200) begin
         if (bus12.in_ready_out) n++;
         @(posedge clk); #1;
         cyc++;
      end
      bus12.in_valid_in = 1'b0;
      chk("acc12_beats", n, 16);
      chk("acc12_valid", bus12.out_valid_out, 1);
      chk("acc12_data", bus12.out_data_out, exp12);
`ifdef REDUCE_SAT_EN
      chk("acc12_const", bus12.out_data_out, 2047);
`else
      chk("acc12_const", bus12.out_data_out, -64);
`endif

      for (int v = 0; v < 25; v++) begin
         cfg = $urandom_range(0, 20);
         q.delete();
         for (int i = 0; i < eff_beats(cfg); i++) q.push_back($urandom);
         run_vector($sformatf("rand%0d", v), cfg, q, $urandom_range(0, 2),
                    $urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
